mu_ctrl: RTL and testbench

Sequencing controller between the execute stage and the multi-cycle multiply unit (`mu`). Accepts one multiply request at a time over a valid/ready handshake, holds operands stable at `mu`, issues a single-cycle `start`, waits for `done`, and returns the result with its destination register over a second valid/ready handshake. Handles pipeline flush while `mu` is busy by draining the in-flight operation. Includes a one-entry last-result cache that answers repeated identical requests without invoking `mu`.

---
 rtl/mu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mu_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu_ctrl.sv
// Sequencer between the execute stage and the multi-cycle multiply unit:
// request/response handshakes, flush draining and a one-entry last-result cache.
module mu_ctrl #(
    parameter logic CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_res,
    output logic [4:0]  rsp_rd,
    output logic        mu_start,
    output logic [31:0] mu_a,
    output logic [31:0] mu_b,
    output logic [1:0]  mu_mulctl,
    input  logic [31:0] mu_res,
    input  logic        mu_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] res_q, res_d;

    logic        cache_valid_q, cache_valid_d;
    logic [31:0] cache_a_q, cache_a_d;
    logic [31:0] cache_b_q, cache_b_d;
    logic [1:0]  cache_op_q, cache_op_d;
    logic [31:0] cache_res_q, cache_res_d;

    logic        accept;
    logic        cache_hit;
    logic        done_ok;
    logic        cache_we;

    assign req_ready = (state_q == S_IDLE) & ~flush;
    assign accept    = req_valid & req_ready;
    assign cache_hit = CACHE_EN & cache_valid_q & (req_a == cache_a_q)
                     & (req_b == cache_b_q) & (req_op == cache_op_q);
    // A done seen while start is still high belongs to an earlier operation.
    assign done_ok   = mu_done & ~start_q;

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        rd_d     = rd_q;
        res_d    = res_q;
        cache_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d  = req_a;
                    b_d  = req_b;
                    op_d = req_op;
                    rd_d = req_rd;
                    if (cache_hit) begin
                        res_d   = cache_res_q;
                        state_d = S_RESP;
                    end else begin
                        start_d = 1'b1;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (done_ok) begin
                    cache_we = 1'b1;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        res_d   = mu_res;
                        state_d = S_RESP;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (done_ok) begin
                    cache_we = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flushed operations still refresh the cache: their result is correct.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_a_d     = cache_a_q;
        cache_b_d     = cache_b_q;
        cache_op_d    = cache_op_q;
        cache_res_d   = cache_res_q;
        if (cache_we) begin
            cache_valid_d = 1'b1;
            cache_a_d     = a_q;
            cache_b_d     = b_q;
            cache_op_d    = op_q;
            cache_res_d   = mu_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            res_q         <= '0;
            cache_valid_q <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_op_q    <= '0;
            cache_res_q   <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            res_q         <= res_d;
            cache_valid_q <= cache_valid_d;
            cache_a_q     <= cache_a_d;
            cache_b_q     <= cache_b_d;
            cache_op_q    <= cache_op_d;
            cache_res_q   <= cache_res_d;
        end
    end

    assign mu_start  = start_q;
    assign mu_a      = a_q;
    assign mu_b      = b_q;
    assign mu_mulctl = op_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_res   = res_q;
    assign rsp_rd    = rd_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mu_ctrl.sv
// Bench for mu_ctrl: plays the multiply unit, tracks an outstanding-transaction
// model with a result cache, and checks outputs every cycle plus literal results.
module tb_mu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [1:0]  req_op = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_res;
    logic [4:0]  rsp_rd;
    logic        mu_start;
    logic [31:0] mu_a;
    logic [31:0] mu_b;
    logic [1:0]  mu_mulctl;
    logic [31:0] mu_res = '0;
    logic        mu_done = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    mu_ctrl #(.CACHE_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_rd(req_rd),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_rd(rsp_rd),
        .mu_start(mu_start), .mu_a(mu_a), .mu_b(mu_b), .mu_mulctl(mu_mulctl),
        .mu_res(mu_res), .mu_done(mu_done), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural multiply result: 64-bit product of the extended operands.
    function automatic logic [31:0] mulres(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00:   p = ua * ub;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Reference model: one outstanding operation at mu, an optional pending
    // response, a killed flag for flushed work and the last completed result.
    logic        m_out = 1'b0, m_kill = 1'b0, m_rsp = 1'b0, m_start = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [1:0]  m_op = '0;
    logic [4:0]  m_rd = '0;
    logic        c_valid = 1'b0;
    logic [31:0] c_a = '0, c_b = '0, c_res = '0;
    logic [1:0]  c_op = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   <= 1'b0;
            m_kill  <= 1'b0;
            m_rsp   <= 1'b0;
            m_start <= 1'b0;
            c_valid <= 1'b0;
        end else begin
            m_start <= 1'b0;
            if (m_out) begin
                if (mu_done && !m_start) begin
                    c_valid <= 1'b1;
                    c_a     <= m_a;
                    c_b     <= m_b;
                    c_op    <= m_op;
                    c_res   <= mulres(m_op, m_a, m_b);
                    m_out   <= 1'b0;
                    if (!m_kill && !flush) begin
                        m_rsp <= 1'b1;
                        m_res <= mulres(m_op, m_a, m_b);
                    end
                end else if (flush) begin
                    m_kill <= 1'b1;
                end
            end else if (m_rsp) begin
                if (flush || rsp_ready) m_rsp <= 1'b0;
            end else if (req_valid && !flush) begin
                m_a  <= req_a;
                m_b  <= req_b;
                m_op <= req_op;
                m_rd <= req_rd;
                if (c_valid && c_a == req_a && c_b == req_b && c_op == req_op) begin
                    m_rsp <= 1'b1;
                    m_res <= c_res;
                end else begin
                    m_out   <= 1'b1;
                    m_kill  <= 1'b0;
                    m_start <= 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_rsp_valid", rsp_valid, 1'b0);
            chk1("rst_mu_start", mu_start, 1'b0);
            chk1("rst_req_ready", req_ready, !flush);
        end else begin
            chk1("busy", busy, m_out | m_rsp);
            chk1("rsp_valid", rsp_valid, m_rsp);
            chk1("req_ready", req_ready, !(m_out | m_rsp) && !flush);
            chk1("mu_start", mu_start, m_start);
            if (m_rsp) begin
                chk("rsp_res", rsp_res, m_res);
                chk("rsp_rd", {27'b0, rsp_rd}, {27'b0, m_rd});
            end
            if (m_out) begin
                chk("mu_a", mu_a, m_a);
                chk("mu_b", mu_b, m_b);
                chk("mu_mulctl", {30'b0, mu_mulctl}, {30'b0, m_op});
            end
        end
    end

    int n_start = 0;
    initial forever begin
        @(negedge clk);
        if (mu_start) n_start++;
    end

    // Multiply unit stand-in; ignores rst_n so an abandoned op still reports done.
    int          mu_lat = 3;
    int          mu_cnt = 0;
    logic        stale_once = 1'b0;
    logic [31:0] cap_a = '0, cap_b = '0;
    logic [1:0]  cap_op = '0;
    initial forever begin
        @(posedge clk);
        #1;
        mu_done = 1'b0;
        if (mu_cnt > 0) begin
            mu_cnt--;
            if (mu_cnt == 0) begin
                mu_done = 1'b1;
                mu_res  = mulres(cap_op, cap_a, cap_b);
            end
        end
        if (mu_start) begin
            cap_a  = mu_a;
            cap_b  = mu_b;
            cap_op = mu_mulctl;
            mu_cnt = mu_lat;
            if (stale_once) begin
                mu_done    = 1'b1;
                mu_res     = 32'hDEAD_BEEF;
                stale_once = 1'b0;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                $display("req  op=%0d a=%08h b=%08h rd=%0d accepted at %0t", op, a, b, rd, $time);
                return;
            end
        end
        chk1("send_timeout", 1'b0, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [31:0] res, input logic [4:0] rd);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk(name, rsp_res, res);
                chk({name, "_rd"}, {27'b0, rsp_rd}, {27'b0, rd});
                $display("rsp  %s res=%08h rd=%0d at %0t", name, rsp_res, rsp_rd, $time);
                @(posedge clk);
                #1;
                return;
            end
        end
        chk1({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk1("idle_timeout", 1'b0, 1'b1);
    endtask

    task automatic expect_hit(input string name, input logic [31:0] res, input logic [4:0] rd);
        @(negedge clk);
        chk1({name, "_latency"}, rsp_valid, 1'b1);
        chk(name, rsp_res, res);
        chk({name, "_rd"}, {27'b0, rsp_rd}, {27'b0, rd});
        $display("rsp  %s res=%08h rd=%0d at %0t", name, rsp_res, rsp_rd, $time);
        @(posedge clk);
        #1;
    endtask

    int s0;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_mu_a", mu_a, 32'h0);
        chk("rst_mu_b", mu_b, 32'h0);
        chk("rst_rsp_res", rsp_res, 32'h0);
        chk("rst_rsp_rd", {27'b0, rsp_rd}, 32'h0);
        chk("rst_mulctl", {30'b0, mu_mulctl}, 32'h0);
        chk1("rst_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk1("rst_ready_flush", req_ready, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        rst_n = 1'b1;

        // MUL miss
        mu_lat = 3;
        s0 = n_start;
        send(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd5);
        wait_rsp("mul_m3_m4", 32'd12, 5'd5);
        chk("mul_starts", 32'(n_start - s0), 32'd1);

        // Repeat: cache hit, then a different miss
        s0 = n_start;
        send(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd6);
        expect_hit("mul_hit", 32'd12, 5'd6);
        chk("hit_starts", 32'(n_start - s0), 32'd0);
        send(2'b00, 32'd16, 32'd48, 5'd7);
        wait_rsp("mul_16_48", 32'd768, 5'd7);
        chk("miss_starts", 32'(n_start - s0), 32'd1);

        // High-half variants back to back; a stale done rides on the first start
        s0 = n_start;
        stale_once = 1'b1;
        send(2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd1);
        wait_rsp("mulh", 32'h0000_0000, 5'd1);
        send(2'b10, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd2);
        wait_rsp("mulhsu", 32'hFFFF_FFFD, 5'd2);
        send(2'b11, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd3);
        wait_rsp("mulhu", 32'hFFFF_FFF9, 5'd3);
        chk("high_starts", 32'(n_start - s0), 32'd3);

        // Flush two cycles after start: drain, then the same operands hit
        mu_lat = 6;
        s0 = n_start;
        send(2'b00, 32'd7, 32'd9, 5'd4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk1("drain_busy", busy, 1'b1);
        chk1("drain_no_rsp", rsp_valid, 1'b0);
        chk1("drain_ready", req_ready, 1'b0);
        wait_idle();
        send(2'b00, 32'd7, 32'd9, 5'd8);
        expect_hit("flush_hit", 32'd63, 5'd8);
        chk("flush_starts", 32'(n_start - s0), 32'd1);

        // Response backpressure, then flush together with rsp_ready
        mu_lat = 2;
        rsp_ready = 1'b0;
        send(2'b00, 32'd5, 32'd6, 5'd9);
        wait_rsp("bp_first", 32'd30, 5'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_valid", rsp_valid, 1'b1);
            chk("bp_res", rsp_res, 32'd30);
            chk("bp_rd", {27'b0, rsp_rd}, 32'd9);
            chk1("bp_ready", req_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        flush = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk1("bp_dropped", rsp_valid, 1'b0);
        chk1("bp_idle", busy, 1'b0);

        // Reset mid-BUSY; late done must be ignored, cache must be empty
        mu_lat = 8;
        s0 = n_start;
        send(2'b00, 32'd11, 32'd13, 5'd10);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_start", mu_start, 1'b0);
        chk1("midrst_valid", rsp_valid, 1'b0);
        chk("midrst_mu_a", mu_a, 32'h0);
        chk("midrst_mu_b", mu_b, 32'h0);
        chk("midrst_rsp_res", rsp_res, 32'h0);
        chk("midrst_rsp_rd", {27'b0, rsp_rd}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk1("late_done_no_rsp", rsp_valid, 1'b0);
        mu_lat = 3;
        send(2'b00, 32'd11, 32'd13, 5'd11);
        wait_rsp("after_rst", 32'd143, 5'd11);
        send(2'b00, 32'd5, 32'd6, 5'd12);
        wait_rsp("cache_cleared", 32'd30, 5'd12);
        chk("rst_starts", 32'(n_start - s0), 32'd3);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
